// File: rtl/lock_ctrl.sv
// Sequencing controller for the three-digit keypad lock. It owns the entry,
// the stored password, the fail counter and the lockout/relock timers.
module lock_ctrl #(
  parameter logic [11:0] DEFAULT_PASS = 12'h123,
  parameter int          MAX_FAIL     = 3,
  parameter int          LOCKOUT_CYC  = 1000,
  parameter int          RELOCK_CYC   = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [11:0] pass_in,
  output logic [11:0] pass_set,
  output logic        mode,
  output logic        L,
  output logic        show,
  output logic        unlock,
  output logic        alarm,
  output logic [2:0]  fail_cnt
);

  localparam int LW = $clog2(LOCKOUT_CYC);
  localparam int RW = $clog2(RELOCK_CYC);

  localparam logic [3:0] K_ENTER = 4'hA;
  localparam logic [3:0] K_CLEAR = 4'hB;
  localparam logic [3:0] K_SET   = 4'hC;
  localparam logic [3:0] K_SHOW  = 4'hD;
  localparam logic [3:0] K_LOCK  = 4'hE;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_CHECK,
    S_UNLOCKED,
    S_SET,
    S_LOCKOUT
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] code;
  } key_t;

  key_t          key;
  state_t        state, state_d;
  logic [1:0]    cnt, cnt_d;
  logic [LW-1:0] lock_tmr, lock_tmr_d;
  logic [RW-1:0] relock_tmr, relock_tmr_d;
  logic [11:0]   pass_in_d, pass_set_d;
  logic [2:0]    fail_d;
  logic          show_d, unlock_d, relock;
  logic          is_digit, full, entry_en;
  logic          k_enter, k_clear, k_set, k_show, k_lock;

  assign key      = '{vld: key_valid, code: key_code};
  assign is_digit = key.vld && (key.code <= 4'd9);
  assign full     = (cnt == 2'd3);
  assign entry_en = (state == S_LOCKED) || (state == S_UNLOCKED) || (state == S_SET);
  assign k_enter  = key.vld && (key.code == K_ENTER);
  assign k_clear  = key.vld && (key.code == K_CLEAR);
  assign k_set    = key.vld && (key.code == K_SET);
  assign k_show   = key.vld && (key.code == K_SHOW);
  assign k_lock   = key.vld && (key.code == K_LOCK);

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    pass_in_d    = pass_in;
    pass_set_d   = pass_set;
    fail_d       = fail_cnt;
    show_d       = show;
    lock_tmr_d   = lock_tmr;
    relock_tmr_d = relock_tmr;
    unlock_d     = 1'b0;
    relock       = 1'b0;

    // Shift-in digit entry; a fourth digit is dropped.
    if (entry_en && is_digit && !full) begin
      pass_in_d = {pass_in[7:0], key.code};
      cnt_d     = cnt + 2'd1;
    end
    if (k_clear && (state != S_LOCKOUT)) begin
      pass_in_d = '0;
      cnt_d     = '0;
    end

    case (state)
      S_LOCKED: begin
        if (k_enter && full) state_d = S_CHECK;
      end
      S_CHECK: begin
        pass_in_d = '0;
        cnt_d     = '0;
        if (pass_in == pass_set) begin
          state_d      = S_UNLOCKED;
          unlock_d     = 1'b1;
          fail_d       = '0;
          relock_tmr_d = '0;
        end else if (({1'b0, fail_cnt} + 4'd1) == 4'(MAX_FAIL)) begin
          state_d    = S_LOCKOUT;
          fail_d     = 3'(MAX_FAIL);
          lock_tmr_d = LW'(LOCKOUT_CYC - 1);
        end else begin
          state_d = S_LOCKED;
          fail_d  = fail_cnt + 3'd1;
        end
      end
      S_LOCKOUT: begin
        if (lock_tmr == '0) begin
          state_d = S_LOCKED;
          fail_d  = '0;
        end else begin
          lock_tmr_d = lock_tmr - LW'(1);
        end
      end
      S_UNLOCKED, S_SET: begin
        // Any key restarts the idle count, even on the expiry cycle.
        if (key.vld)                                 relock_tmr_d = '0;
        else if (relock_tmr == RW'(RELOCK_CYC - 1)) relock       = 1'b1;
        else                                         relock_tmr_d = relock_tmr + RW'(1);

        if (relock) begin
          state_d      = S_LOCKED;
          pass_in_d    = '0;
          cnt_d        = '0;
          relock_tmr_d = '0;
        end else if (state == S_UNLOCKED) begin
          if (k_lock) begin
            state_d   = S_LOCKED;
            pass_in_d = '0;
            cnt_d     = '0;
          end else if (k_set) begin
            state_d   = S_SET;
            pass_in_d = '0;
            cnt_d     = '0;
          end else if (k_show) begin
            show_d = ~show;
          end
        end else begin
          if (k_enter && full) begin
            state_d    = S_UNLOCKED;
            pass_set_d = pass_in;
            pass_in_d  = '0;
            cnt_d      = '0;
          end else if (k_clear && (cnt == 2'd0)) begin
            state_d = S_UNLOCKED;
          end
        end
      end
      default: state_d = S_LOCKED;
    endcase

    if (state_d != S_UNLOCKED) show_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOCKED;
      cnt        <= '0;
      pass_in    <= '0;
      pass_set   <= DEFAULT_PASS;
      fail_cnt   <= '0;
      show       <= 1'b0;
      unlock     <= 1'b0;
      mode       <= 1'b0;
      L          <= 1'b1;
      alarm      <= 1'b0;
      lock_tmr   <= '0;
      relock_tmr <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      pass_in    <= pass_in_d;
      pass_set   <= pass_set_d;
      fail_cnt   <= fail_d;
      show       <= show_d;
      unlock     <= unlock_d;
      mode       <= (state_d == S_SET);
      L          <= !((state_d == S_UNLOCKED) || (state_d == S_SET));
      alarm      <= (state_d == S_LOCKOUT);
      lock_tmr   <= lock_tmr_d;
      relock_tmr <= relock_tmr_d;
    end
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed scenarios plus random keys against a
// behavioural model of the lock's rules.
module tb_lock_ctrl;

  localparam logic [11:0] DEF = 12'h123;
  localparam int MF = 3;
  localparam int LC = 12;
  localparam int RC = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [11:0] pass_in, pass_set;
  logic        mode, L, show, unlock, alarm;
  logic [2:0]  fail_cnt;
  logic [31:0] dut_vec;

  lock_ctrl #(.DEFAULT_PASS(DEF), .MAX_FAIL(MF), .LOCKOUT_CYC(LC), .RELOCK_CYC(RC)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .pass_in(pass_in), .pass_set(pass_set), .mode(mode), .L(L), .show(show),
    .unlock(unlock), .alarm(alarm), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;
  assign dut_vec = {pass_in, pass_set, mode, L, show, unlock, alarm, fail_cnt};

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: flags, counters and a digit queue.
  bit          m_unl, m_set, m_chk, m_show, m_pulse;
  int          m_lo, m_idle, m_fails;
  logic [11:0] m_pass;
  logic [3:0]  m_dig[$];

  function automatic logic [11:0] m_entry();
    logic [11:0] v = '0;
    foreach (m_dig[i]) v = {v[7:0], m_dig[i]};
    return v;
  endfunction

  function automatic logic [31:0] exp_vec();
    return {m_entry(), m_pass, m_set, !m_unl, m_show, m_pulse, (m_lo > 0), 3'(m_fails)};
  endfunction

  task automatic model_reset();
    m_unl = 0; m_set = 0; m_chk = 0; m_show = 0; m_pulse = 0;
    m_lo = 0; m_idle = 0; m_fails = 0; m_pass = DEF; m_dig.delete();
  endtask

  task automatic model_step(input bit kv, input logic [3:0] kc);
    m_pulse = 0;
    if (m_lo > 0) begin
      m_lo--;
      if (m_lo == 0) m_fails = 0;
      return;
    end
    if (m_chk) begin
      m_chk = 0;
      if (m_entry() == m_pass) begin
        m_unl = 1; m_pulse = 1; m_fails = 0; m_idle = 0;
      end else begin
        m_fails++;
        if (m_fails == MF) m_lo = LC;
      end
      m_dig.delete();
      return;
    end
    if (!m_unl) begin
      if (kv && kc <= 9 && m_dig.size() < 3) m_dig.push_back(kc);
      else if (kv && kc == 4'hB) m_dig.delete();
      else if (kv && kc == 4'hA && m_dig.size() == 3) m_chk = 1;
      return;
    end
    if (kv) m_idle = 0;
    else begin
      m_idle++;
      if (m_idle == RC) begin
        m_unl = 0; m_set = 0; m_show = 0; m_idle = 0; m_dig.delete();
      end
      return;
    end
    if (kc <= 9) begin
      if (m_dig.size() < 3) m_dig.push_back(kc);
    end else if (kc == 4'hB) begin
      if (m_set && m_dig.size() == 0) m_set = 0;
      m_dig.delete();
    end else if (m_set) begin
      if (kc == 4'hA && m_dig.size() == 3) begin
        m_pass = m_entry(); m_set = 0; m_dig.delete();
      end
    end else if (kc == 4'hE) begin
      m_unl = 0; m_show = 0; m_dig.delete();
    end else if (kc == 4'hC) begin
      m_set = 1; m_show = 0; m_dig.delete();
    end else if (kc == 4'hD) begin
      m_show = !m_show;
    end
  endtask

  task automatic tick(input bit kv, input logic [3:0] kc);
    key_valid = kv; key_code = kc;
    @(posedge clk);
    model_step(kv, kc);
    #1;
    key_valid = 1'b0; key_code = 4'h0;
  endtask

  task automatic press_hex(input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, seq[4*(n-1-i) +: 4]);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    n_total++;
    if (dut_vec !== {12'h0, DEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0})
      $display("FAIL reset_values: got %h want %h", dut_vec, {12'h0, DEF, 8'b01000000});
    else n_pass++;
    #9 rst_n = 1'b1;
  endtask

  task automatic test_unlock();
    press_hex(32'h123A, 4);
    n_total++;
    if (dut_vec !== exp_vec()) $display("FAIL unlock_check_cycle: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
    tick(1'b0, 4'h0);
    n_total++;
    if ({L, unlock, fail_cnt, pass_in} !== {1'b0, 1'b1, 3'd0, 12'h0})
      $display("FAIL unlock_pulse: got %h want %h", {L, unlock, fail_cnt, pass_in}, {1'b0, 1'b1, 3'd0, 12'h0});
    else n_pass++;
    tick(1'b0, 4'h0);
    n_total++;
    if ({L, unlock} !== 2'b00) $display("FAIL unlock_one_cycle: got %b want 00", {L, unlock});
    else n_pass++;
    tick(1'b1, 4'hE);
    n_total++;
    if (dut_vec !== exp_vec() || L !== 1'b1) $display("FAIL relock_key: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_lockout();
    int cyc = 0;
    for (int a = 0; a < MF; a++) begin
      press_hex(32'h999A, 4);
      tick(1'b0, 4'h0);
      n_total++;
      if (a < MF - 1) begin
        if ({alarm, fail_cnt} !== {1'b0, 3'(a + 1)})
          $display("FAIL fail_count: got %h want %h", {alarm, fail_cnt}, {1'b0, 3'(a + 1)});
        else n_pass++;
      end else begin
        if ({alarm, fail_cnt} !== {1'b1, 3'(MF)})
          $display("FAIL lockout_enter: got %h want %h", {alarm, fail_cnt}, {1'b1, 3'(MF)});
        else n_pass++;
      end
    end
    while (alarm === 1'b1 && cyc < LC + 5) begin
      cyc++;
      tick(cyc == 3, 4'h1);
      n_total++;
      if (dut_vec !== exp_vec() || pass_in !== 12'h0)
        $display("FAIL lockout_cycle: got %h want %h", dut_vec, exp_vec());
      else n_pass++;
    end
    n_total++;
    if (cyc !== LC) $display("FAIL alarm_length: got %0d want %0d", cyc, LC);
    else n_pass++;
    n_total++;
    if ({L, alarm, fail_cnt} !== {1'b1, 1'b0, 3'd0})
      $display("FAIL lockout_exit: got %h want %h", {L, alarm, fail_cnt}, 5'b10000);
    else n_pass++;
  endtask

  task automatic test_set_password();
    press_hex(32'h123A, 4);
    tick(1'b0, 4'h0);
    tick(1'b1, 4'hC);
    n_total++;
    if ({mode, L} !== 2'b10) $display("FAIL set_enter: got %b want 10", {mode, L});
    else n_pass++;
    press_hex(32'h456A, 4);
    n_total++;
    if ({mode, pass_set} !== {1'b0, 12'h456}) $display("FAIL set_store: got %h want %h", {mode, pass_set}, {1'b0, 12'h456});
    else n_pass++;
    tick(1'b1, 4'hE);
    press_hex(32'h123A, 4);
    tick(1'b0, 4'h0);
    n_total++;
    if ({L, fail_cnt} !== {1'b1, 3'd1}) $display("FAIL old_pass_rejected: got %h want %h", {L, fail_cnt}, 4'h9);
    else n_pass++;
    press_hex(32'h456A, 4);
    tick(1'b0, 4'h0);
    n_total++;
    if ({L, fail_cnt, unlock} !== {1'b0, 3'd0, 1'b1}) $display("FAIL new_pass_unlock: got %h want %h", {L, fail_cnt, unlock}, 5'b00001);
    else n_pass++;
    tick(1'b1, 4'hE);
    n_total++;
    if (dut_vec !== exp_vec()) $display("FAIL set_model: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_entry_limits();
    press_hex(32'h7891, 4);
    n_total++;
    if (pass_in !== 12'h789) $display("FAIL fourth_digit: got %h want 789", pass_in);
    else n_pass++;
    tick(1'b1, 4'hB);
    n_total++;
    if (pass_in !== 12'h000) $display("FAIL clear_key: got %h want 000", pass_in);
    else n_pass++;
    press_hex(32'h12A, 3);
    tick(1'b0, 4'h0);
    n_total++;
    if ({L, pass_in} !== {1'b1, 12'h012}) $display("FAIL short_enter: got %h want %h", {L, pass_in}, {1'b1, 12'h012});
    else n_pass++;
    tick(1'b1, 4'hB);
    n_total++;
    if (dut_vec !== exp_vec()) $display("FAIL entry_model: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_show_relock();
    press_hex(32'h456A, 4);
    tick(1'b0, 4'h0);
    tick(1'b1, 4'hD);
    n_total++;
    if (show !== 1'b1) $display("FAIL show_on: got %b want 1", show);
    else n_pass++;
    tick(1'b1, 4'hD);
    n_total++;
    if (show !== 1'b0) $display("FAIL show_off: got %b want 0", show);
    else n_pass++;
    tick(1'b1, 4'hD);
    repeat (RC - 1) tick(1'b0, 4'h0);
    n_total++;
    if ({L, show} !== 2'b01) $display("FAIL before_expiry: got %b want 01", {L, show});
    else n_pass++;
    tick(1'b1, 4'hF);
    n_total++;
    if ({L, show} !== 2'b01) $display("FAIL key_on_expiry: got %b want 01", {L, show});
    else n_pass++;
    repeat (RC - 1) tick(1'b0, 4'h0);
    n_total++;
    if (L !== 1'b0) $display("FAIL early_relock: got %b want 0", L);
    else n_pass++;
    tick(1'b0, 4'h0);
    n_total++;
    if ({L, show} !== 2'b10 || dut_vec !== exp_vec())
      $display("FAIL auto_relock: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_reset_mid_set();
    press_hex(32'h456A, 4);
    tick(1'b0, 4'h0);
    press_hex(32'hC78, 3);
    n_total++;
    if ({mode, pass_in} !== {1'b1, 12'h078}) $display("FAIL mid_set_entry: got %h want %h", {mode, pass_in}, {1'b1, 12'h078});
    else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({pass_in, mode, L, pass_set} !== {12'h0, 1'b0, 1'b1, DEF})
      $display("FAIL async_reset: got %h want %h", {pass_in, mode, L, pass_set}, {12'h0, 2'b01, DEF});
    else n_pass++;
    #3 rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0]  kc;
    logic [11:0] p;
    bit          kv;
    int          sz, prob;
    for (int c = 0; c < 2500; c++) begin
      prob = (((c / 200) % 3) == 2) ? 2 : 50;
      kv = ($urandom_range(0, 99) < prob);
      sz = m_dig.size();
      p  = m_pass;
      if ($urandom_range(0, 9) < 4) kc = (sz < 3) ? p[4*(2-sz) +: 4] : 4'hA;
      else kc = 4'($urandom_range(0, 15));
      tick(kv, kc);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL random_c%0d: got %h want %h", c, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_set_password();
    test_entry_limits();
    test_show_relock();
    test_reset_mid_set();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
